// File: rtl/regfile_write_sched.sv
// Write-port scheduler for the register file: shares the single write port
// round-robin among NREQ requesters and sequences a full clear after reset or on request.
module regfile_write_sched #(
  parameter int NREQ  = 3,
  parameter int Nloc  = 32,
  parameter int Dbits = 32,
  parameter int AW    = $clog2(Nloc)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*Dbits-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rf_wr,
  output logic [AW-1:0]         rf_waddr,
  output logic [Dbits-1:0]      rf_wdata,
  output logic                  busy,
  output logic                  init_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: a requester transfers in any cycle where req_valid[i] & req_ready[i];
  // req_ready may follow req_valid combinationally, never the other way round.
  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [AW-1:0]     r_clr_cnt;
  logic [PW-1:0]     r_rr_ptr;
  logic              w_any;
  logic [PW-1:0]     w_gnt_idx;
  logic [PW:0]       w_idx;
  logic              w_xfer;
  logic              w_clr_last;
  logic [AW-1:0]     w_gnt_addr;
  logic [Dbits-1:0]  w_gnt_data;

  assign w_clr_last = (r_clr_cnt == AW'(Nloc - 1));

  // Rotating priority search starting just after the last granted requester.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NREQ)) w_idx = w_idx - (PW+1)'(NREQ);
      if (!w_any && req_valid[w_idx[PW-1:0]]) begin
        w_any     = 1'b1;
        w_gnt_idx = w_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    w_gnt_addr = '0;
    w_gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_idx == PW'(i)) begin
        w_gnt_addr = req_addr[i*AW +: AW];
        w_gnt_data = req_data[i*Dbits +: Dbits];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_CLEAR;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_CLEAR: if (w_clr_last) w_next_state = S_RUN;
      S_RUN:   if (clear)      w_next_state = S_CLEAR;
      default: w_next_state = S_CLEAR;
    endcase
  end

  always_comb begin
    w_xfer    = (r_state == S_RUN) && !clear && w_any;
    req_ready = '0;
    if (w_xfer) req_ready[w_gnt_idx] = 1'b1;
    busy = (r_state == S_CLEAR);
  end

  // Register-file drive, clear counter and round-robin pointer.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_clr_cnt <= '0;
      r_rr_ptr  <= PW'(NREQ - 1);
      rf_wr     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      init_done <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      rf_wr    <= 1'b1;
      rf_waddr <= r_clr_cnt;
      rf_wdata <= '0;
      if (w_clr_last) begin
        r_clr_cnt <= '0;
        init_done <= 1'b1;
      end else begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end else if (clear) begin
      rf_wr     <= 1'b0;
      r_clr_cnt <= '0;
      init_done <= 1'b0;
    end else if (w_xfer) begin
      rf_wr    <= (w_gnt_addr != '0);
      rf_waddr <= w_gnt_addr;
      rf_wdata <= w_gnt_data;
      r_rr_ptr <= w_gnt_idx;
    end else begin
      rf_wr <= 1'b0;
    end
  end

endmodule

// File: doc/regfile_write_sched.md
# regfile_write_sched

Write-port scheduler for the 32 x 32 MIPS register file. It owns the register file's single write port and shares it round-robin among NREQ writeback requesters: ALU writeback, load unit, and debug/VGA poke. It also sequences a hardware clear of every register after reset or on command. All outputs driving the register file are registered; the register file's read ports are untouched.

## Interface
- NREQ, 3, number of write requesters (2..8)
- Nloc, 32, number of register-file locations
- Dbits, 32, data width
- AW, 5, address width, equal to $clog2(Nloc)
- clock  in  1  rising-edge clock shared with the register file
- resetn  in  1  asynchronous, active-low reset
- clear  in  1  request to re-run the full clear sequence (level, sampled in RUN)
- req_valid  in  NREQ  requester i has a write pending
- req_addr  in  NREQ*AW  packed destination addresses; requester i at [i*AW +: AW]
- req_data  in  NREQ*Dbits  packed write data; requester i at [i*Dbits +: Dbits]
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- rf_wr  out  1  register-file write enable (registered)
- rf_waddr  out  AW  register-file write address (registered)
- rf_wdata  out  Dbits  register-file write data (registered)
- busy  out  1  high while in CLEAR (combinational from state)
- init_done  out  1  registered; goes high the cycle after CLEAR exits, low on entry to CLEAR

## Operation
- Two states: CLEAR and RUN. Reset state is CLEAR.
- Reset values: state=CLEAR, clr_cnt=0, rr_ptr=NREQ-1, rf_wr=0, rf_waddr=0, rf_wdata=0, init_done=0.
- **CLEAR state.**
  - req_ready=0.
  - Each edge registers rf_wr=1, rf_waddr=clr_cnt, rf_wdata=0, then increments clr_cnt.
  - When clr_cnt==Nloc-1, the next state is RUN and clr_cnt returns to 0.
  - Address 0 is physically written in CLEAR.
- **RUN state, arbitration.**
  - Search req_valid starting at index rr_ptr+1 (mod NREQ), wrapping around.
  - The first valid index found gets req_ready=1; all other bits are 0.
  - req_ready is 0 for every requester when no req_valid is set, or when clear=1.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- **RUN state, transfer by requester g.**
  - Next edge: rf_waddr=addr_g, rf_wdata=data_g, rf_wr=(addr_g!=0), rr_ptr=g.
  - A write to address 0 is accepted (handshake completes) but suppressed (rf_wr=0).
- **RUN state, no transfer.**
  - rf_wr<=0; rf_waddr and rf_wdata hold; rr_ptr holds.
- **RUN state with clear=1.**
  - No grant that cycle.
  - Next state is CLEAR, clr_cnt=0, init_done<=0.
  - clear is ignored while in CLEAR. A clear held high re-enters CLEAR after each RUN cycle.
- Requesters hold addr and data stable while valid and not ready. The scheduler does not check this.
- rr_ptr is not reset on re-entry to CLEAR.

## Timing
- From resetn deassertion, the first rising edge issues clear write 0. rf_wr is high for exactly Nloc consecutive cycles (addresses 0..Nloc-1).
- busy falls and RUN begins on the edge that registers address Nloc-1. init_done rises on that same edge.
- The first grant is possible in the cycle that register Nloc-1 is written.
- Write latency: a handshake in cycle t gives rf_wr/addr/data valid in cycle t+1. The register file captures the data at the end of t+1.
- Throughput: one write per cycle sustained.
- Fairness: with all NREQ requesters continuously valid, each requester is granted exactly once per NREQ cycles.
- resetn asserted mid-CLEAR or mid-RUN immediately forces all reset values (asynchronous). A pending output write is dropped, and the clear sequence restarts from address 0.
- The scheduler does not resolve read-after-write ordering. A value written in cycle t+1 is readable combinationally from cycle t+2.

## Test plan
- **Reset and clear.** Release resetn, all req_valid=0.
  - rf_wr=1 for 32 cycles with rf_waddr 0,1,..,31 and rf_wdata=0.
  - busy falls after the 32nd write; init_done=1 thereafter.
  - req_ready stays 0 throughout CLEAR.
- **Single requester.** After init, req_valid=3'b010, addr=5, data=32'hDEADBEEF for one cycle.
  - req_ready=3'b010 that cycle.
  - Next cycle: rf_wr=1, rf_waddr=5, rf_wdata=32'hDEADBEEF.
  - The following cycle: rf_wr=0.
- **Round-robin.** After init, all three valid continuously.
  - Grant sequence is 0,1,2,0,1,2…
  - rf_waddr tracks each requester's address, with one write per cycle.
- **Address zero.** Requester 0 writes addr=0, data=32'h1234.
  - Handshake completes; next cycle rf_wr=0.
  - rr_ptr advances, so requester 1 wins next when both are valid.
- **Clear mid-run.** In RUN, all valid, pulse clear for one cycle.
  - No grant that cycle.
  - Next 32 cycles: clear writes 0..31 with req_ready=0 and init_done=0.
  - Grants then resume from requester rr_ptr+1.
- **Reset mid-clear.** Assert resetn low during clear write 17.
  - Outputs go to reset values immediately.
  - After release, clearing restarts at address 0 and takes the full 32 cycles.
